// File: rtl/axis_core_sequencer_if.sv
// axis_core_sequencer_if: bundle of all sequencer-facing signals.
// Groups:
//   s_axis_*  input stream from the MM2S FIFO (tdata/tvalid/tlast in, tready out)
//   core_wr_* buffer write port (en/addr/data), core_start pulse, core_finish level
//   core_rd_* buffer read port (en/addr out, data back one cycle later)
//   m_axis_*  output stream to the S2MM FIFO (tdata/tvalid/tlast out, tready in)
//   err_tlast, err_timeout, job_count, busy: status for software
// Modport master is the sequencer's view; slave is the surrounding system's view.
interface axis_core_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic              core_wr_en;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_wr_data;
    logic              core_start;
    logic              core_finish;
    logic              core_rd_en;
    logic [ADDR_W-1:0] core_rd_addr;
    logic [DATA_W-1:0] core_rd_data;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              err_tlast;
    logic              err_timeout;
    logic [15:0]       job_count;
    logic              busy;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output core_wr_en, core_wr_addr, core_wr_data, core_start,
        input  core_finish,
        output core_rd_en, core_rd_addr,
        input  core_rd_data,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output err_tlast, err_timeout, job_count, busy
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  core_wr_en, core_wr_addr, core_wr_data, core_start,
        output core_finish,
        input  core_rd_en, core_rd_addr,
        output core_rd_data,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  err_tlast, err_timeout, job_count, busy
    );
endinterface

// File: rtl/axis_core_sequencer.sv
// axis_core_sequencer: loads a fixed-length AXIS packet into the core buffer,
// starts the core, waits for finish (with timeout) and streams the results out.
// Ports:
//   aclk    - single clock
//   aresetn - synchronous active-low reset
//   bus     - axis_core_sequencer_if.master: input stream, core buffer write/read
//             ports, core start/finish, output stream and status (err_tlast,
//             err_timeout, job_count, busy)
module axis_core_sequencer #(
    parameter int DATA_W      = 64,
    parameter int IN_WORDS    = 5,
    parameter int OUT_WORDS   = 5,
    parameter int ADDR_W      = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic aclk,
    input logic aresetn,
    axis_core_sequencer_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC) > 0 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(IN_WORDS - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_WORDS - 1);
    localparam logic [ADDR_W:0]   OUT_N    = (ADDR_W + 1)'(OUT_WORDS);
    localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W:0]   rcnt;
    logic [TW-1:0]     tcnt;
    logic              inflight, inflight_last;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_last;
    logic              wptr, rptr;
    logic [1:0]        count;
    logic              in_hs, in_last, out_hs, push, pop, timeout;

    assign bus.s_axis_tready = aresetn && (state == IDLE || state == LOAD);
    assign in_hs             = bus.s_axis_tvalid && bus.s_axis_tready;
    assign in_last           = wcnt == IN_LAST;
    assign bus.core_wr_en    = in_hs;
    assign bus.core_wr_addr  = wcnt;
    assign bus.core_wr_data  = bus.s_axis_tdata;
    assign bus.core_start    = state == START;
    assign timeout           = tcnt == TO_LAST;

    // Occupancy counts words already in the skid FIFO plus the read in flight,
    // so at most two words are ever outstanding and none can be dropped.
    assign bus.core_rd_en   = state == DRAIN && rcnt < OUT_N && (count + 2'(inflight)) < 2'd2;
    assign bus.core_rd_addr = rcnt[ADDR_W-1:0];

    // An empty FIFO is bypassed by the returning read so the first beat leaves
    // the cycle after issue; a stalled bypass word is captured and replayed.
    assign bus.m_axis_tvalid = count != 2'd0 || inflight;
    assign bus.m_axis_tdata  = count != 2'd0 ? fifo_data[rptr] : inflight ? bus.core_rd_data : '0;
    assign bus.m_axis_tlast  = count != 2'd0 ? fifo_last[rptr] : inflight_last;
    assign out_hs            = bus.m_axis_tvalid && bus.m_axis_tready;
    assign pop               = out_hs && count != 2'd0;
    assign push              = inflight && !(out_hs && count == 2'd0);
    assign bus.busy          = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, LOAD: if (in_hs) state_nx = in_last ? START : LOAD;
            START:      state_nx = WAIT;
            WAIT:       if (bus.core_finish || timeout) state_nx = DRAIN;
            DRAIN:      if (out_hs && bus.m_axis_tlast) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= IDLE;
            wcnt            <= '0;
            rcnt            <= '0;
            tcnt            <= '0;
            inflight        <= 1'b0;
            inflight_last   <= 1'b0;
            wptr            <= 1'b0;
            rptr            <= 1'b0;
            count           <= 2'd0;
            bus.err_tlast   <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.job_count   <= '0;
        end else begin
            state <= state_nx;
            if (in_hs) begin
                wcnt <= in_last ? '0 : wcnt + 1'b1;
                if (bus.s_axis_tlast != in_last) bus.err_tlast <= 1'b1;
            end
            tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
            if (state == WAIT && timeout && !bus.core_finish) bus.err_timeout <= 1'b1;
            rcnt          <= state == DRAIN ? rcnt + (ADDR_W + 1)'(bus.core_rd_en) : '0;
            inflight      <= bus.core_rd_en;
            inflight_last <= bus.core_rd_en && bus.core_rd_addr == OUT_LAST;
            if (push) begin
                fifo_data[wptr] <= bus.core_rd_data;
                fifo_last[wptr] <= inflight_last;
                wptr            <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
            if (out_hs && bus.m_axis_tlast) bus.job_count <= bus.job_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_core_sequencer.sv
// tb_axis_core_sequencer: table-driven packet vectors plus hand-written reset,
// early-tlast and back-to-back sequences against a buffer/core model.
module tb_axis_core_sequencer;
    localparam int DW = 64;
    localparam int AW = 3;
    localparam int NW = 5;
    localparam int TO = 16;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axis_core_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    axis_core_sequencer #(
        .DATA_W(DW), .IN_WORDS(NW), .OUT_WORDS(NW), .ADDR_W(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fin_d = 3;
    bit bp_mode = 0;

    // Buffer and core model: finish rises fin_d cycles after the start pulse
    // (fin_d < 0 never finishes); read data returns one cycle after rd_en.
    logic [DW-1:0] mem [2**AW];
    int fcnt;
    always @(posedge aclk) begin
        if (!aresetn) begin
            bus.core_finish  <= 1'b0;
            bus.core_rd_data <= '0;
            fcnt             <= -1;
        end else begin
            if (bus.core_wr_en) mem[bus.core_wr_addr] <= bus.core_wr_data;
            if (bus.core_rd_en) bus.core_rd_data <= mem[bus.core_rd_addr];
            if (bus.core_start) begin
                bus.core_finish <= 1'b0;
                fcnt            <= 1;
            end else if (fcnt >= 0 && fin_d >= 0) begin
                if (fcnt + 1 >= fin_d) bus.core_finish <= 1'b1;
                fcnt <= fcnt + 1;
            end
        end
    end

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Output ready: 1 normally, repeating 1,0,0,1,0,1 under backpressure.
    logic [5:0] bp_pat = 6'b101001;
    int bp_idx = 0;
    initial begin
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (bp_mode) begin
                bus.m_axis_tready = bp_pat[bp_idx % 6];
                bp_idx++;
            end else begin
                bus.m_axis_tready = 1'b1;
                bp_idx = 0;
            end
        end
    end

    // Monitor, sampled mid-cycle.
    logic [AW-1:0] wr_a_q [$];
    logic [DW-1:0] wr_d_q [$];
    logic [DW-1:0] out_d_q [$];
    logic          out_l_q [$];
    int first_wr_q [$];
    int last_beat_q [$];
    int starts = 0, done = 0, issued = 0, outs = 0, max_out = 0, stalls = 0, stall_viol = 0;
    int t_lastwr = -1, t_start = -1, first_rd = -1, first_v = -1, t_lastbeat = -1;
    logic pv = 0, pr = 0, pl = 0;
    logic [DW-1:0] pd = '0;
    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            issued = 0;
            outs = 0;
            pv = 0;
        end else begin
            if (bus.core_wr_en) begin
                wr_a_q.push_back(bus.core_wr_addr);
                wr_d_q.push_back(bus.core_wr_data);
                if (bus.core_wr_addr == AW'(NW - 1)) t_lastwr = cyc;
                if (bus.core_wr_addr == '0) first_wr_q.push_back(cyc);
            end
            if (bus.core_start) begin
                starts++;
                t_start = cyc;
                first_rd = -1;
                first_v = -1;
            end
            if (bus.core_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                issued++;
            end
            if (bus.m_axis_tvalid && first_v < 0) first_v = cyc;
            if (issued - outs > max_out) max_out = issued - outs;
            if (pv && !pr) begin
                stalls++;
                if (!bus.m_axis_tvalid || bus.m_axis_tdata != pd || bus.m_axis_tlast != pl) stall_viol++;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                out_d_q.push_back(bus.m_axis_tdata);
                out_l_q.push_back(bus.m_axis_tlast);
                outs++;
                if (bus.m_axis_tlast) begin
                    t_lastbeat = cyc;
                    last_beat_q.push_back(cyc);
                    done++;
                end
            end
            pv = bus.m_axis_tvalid;
            pr = bus.m_axis_tready;
            pd = bus.m_axis_tdata;
            pl = bus.m_axis_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [NW-1:0][DW-1:0] w, input int lastpos, input bit gaps);
        int n;
        for (int i = 0; i < NW; i++) begin
            if (gaps) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            bus.s_axis_tdata  = w[i];
            bus.s_axis_tlast  = (i == lastpos);
            bus.s_axis_tvalid = 1'b1;
            n = 0;
            while (!bus.s_axis_tready && n < 300) begin
                @(posedge aclk);
                #1;
                n++;
            end
            if (!bus.s_axis_tready) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: word %0d not accepted within %0d cycles", i, n);
                return;
            end
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done < target && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
        end
        checks++;
        if (done < target) begin
            failures++;
            $display("FAIL done_timeout: got %0d packets expected %0d", done, target);
        end
    endtask

    typedef struct packed {
        logic [NW-1:0][DW-1:0] w;
        int lastpos;
        int fin_d;
        bit gaps;
        bit bp;
        bit e_tl;
        bit e_to;
        int e_jobs;
    } vec_t;
    vec_t vt [6];

    initial begin
        int n;
        int ob;
        int d0;
        vt[0] = '{w: {64'h55, 64'h44, 64'h33, 64'h22, 64'h11}, lastpos: 4, fin_d: 3,
                  gaps: 0, bp: 0, e_tl: 0, e_to: 0, e_jobs: 1};
        vt[1] = '{w: {64'h5555_0000_aaaa_ffff, 64'h0f0f_f0f0_0f0f_f0f0, 64'hdead_beef_cafe_f00d,
                      64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef}, lastpos: 4, fin_d: 5,
                  gaps: 1, bp: 0, e_tl: 0, e_to: 0, e_jobs: 2};
        vt[2] = '{w: {64'h105, 64'h104, 64'h103, 64'h102, 64'h101}, lastpos: -1, fin_d: 2,
                  gaps: 0, bp: 0, e_tl: 1, e_to: 0, e_jobs: 3};
        vt[3] = '{w: {64'ha5, 64'ha4, 64'ha3, 64'ha2, 64'ha1}, lastpos: 4, fin_d: 4,
                  gaps: 0, bp: 0, e_tl: 1, e_to: 0, e_jobs: 4};
        vt[4] = '{w: {64'hb5, 64'hb4, 64'hb3, 64'hb2, 64'hb1}, lastpos: 4, fin_d: 3,
                  gaps: 0, bp: 1, e_tl: 1, e_to: 0, e_jobs: 5};
        vt[5] = '{w: {64'hc5, 64'hc4, 64'hc3, 64'hc2, 64'hc1}, lastpos: 4, fin_d: -1,
                  gaps: 0, bp: 0, e_tl: 1, e_to: 1, e_jobs: 6};

        aresetn = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_s_tready", bus.s_axis_tready, 0);
        chk("rst_wr_en", bus.core_wr_en, 0);
        chk("rst_start", bus.core_start, 0);
        chk("rst_rd_en", bus.core_rd_en, 0);
        chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_m_tlast", bus.m_axis_tlast, 0);
        chk("rst_m_tdata", bus.m_axis_tdata, 0);
        chk("rst_wr_addr", bus.core_wr_addr, 0);
        chk("rst_rd_addr", bus.core_rd_addr, 0);
        chk("rst_err_tlast", bus.err_tlast, 0);
        chk("rst_err_timeout", bus.err_timeout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_job_count", bus.job_count, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_s_tready", bus.s_axis_tready, 1);
        @(posedge aclk);
        #1;

        for (int k = 0; k < 6; k++) begin
            int s0, wb, ob2, ft, f;
            fin_d   = vt[k].fin_d;
            bp_mode = vt[k].bp;
            s0  = starts;
            wb  = wr_a_q.size();
            ob2 = out_d_q.size();
            d0  = done;
            send(vt[k].w, vt[k].lastpos, vt[k].gaps);
            bus.s_axis_tvalid = 1'b0;
            bus.s_axis_tlast  = 1'b0;
            wait_done(d0 + 1);
            bp_mode = 0;
            chk("start_pulses", starts - s0, 1);
            chk("wr_count", wr_a_q.size() - wb, NW);
            for (int i = 0; i < NW && wb + i < wr_a_q.size(); i++) begin
                chk("wr_addr", wr_a_q[wb + i], i);
                chk("wr_data", wr_d_q[wb + i], vt[k].w[i]);
            end
            chk("out_count", out_d_q.size() - ob2, NW);
            for (int i = 0; i < NW && ob2 + i < out_d_q.size(); i++) begin
                chk("out_data", out_d_q[ob2 + i], vt[k].w[i]);
                chk("out_last", out_l_q[ob2 + i], i == NW - 1);
            end
            chk("err_tlast", bus.err_tlast, vt[k].e_tl);
            chk("err_timeout", bus.err_timeout, vt[k].e_to);
            chk("job_count", bus.job_count, vt[k].e_jobs);
            chk("busy_after", bus.busy, 0);
            ft = (vt[k].fin_d >= 2 && vt[k].fin_d <= TO) ? vt[k].fin_d : TO;
            f  = t_start + ft;
            chk("start_latency", t_start, t_lastwr + 1);
            chk("first_rd_cycle", first_rd, f + 1);
            chk("first_valid_cycle", first_v, f + 2);
            if (!vt[k].bp) chk("last_beat_cycle", t_lastbeat, f + 1 + NW);
        end
        chk("stall_stable", stall_viol, 0);
        chk("stalls_seen", stalls > 0, 1);
        chk("max_outstanding_le2", max_out <= 2, 1);

        // Reset after two output beats of a packet.
        fin_d = 3;
        ob = out_d_q.size();
        send({64'hd5, 64'hd4, 64'hd3, 64'hd2, 64'hd1}, 4, 0);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        n = 0;
        while (out_d_q.size() - ob < 2 && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("mid_beats_before_reset", out_d_q.size() - ob, 2);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mid_rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_job_count", bus.job_count, 0);
        chk("mid_rst_s_tready", bus.s_axis_tready, 0);
        chk("mid_rst_err_timeout", bus.err_timeout, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_rel_s_tready", bus.s_axis_tready, 1);
        chk("mid_rel_m_tvalid", bus.m_axis_tvalid, 0);
        @(posedge aclk);
        #1;

        // Early tlast on the third word: five words still loaded.
        ob = out_d_q.size();
        n  = wr_a_q.size();
        d0 = done;
        send({64'he5, 64'he4, 64'he3, 64'he2, 64'he1}, 2, 0);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        wait_done(d0 + 1);
        chk("early_err_tlast", bus.err_tlast, 1);
        chk("early_wr_count", wr_a_q.size() - n, NW);
        chk("early_out_count", out_d_q.size() - ob, NW);
        if (out_d_q.size() - ob == NW) begin
            chk("early_out4", out_d_q[ob + 4], 64'he5);
            chk("early_last4", out_l_q[ob + 4], 1);
            chk("early_last2", out_l_q[ob + 2], 0);
        end
        chk("early_job_count", bus.job_count, 1);

        // Back-to-back packets with tvalid held high throughout.
        n  = first_wr_q.size();
        ob = last_beat_q.size();
        d0 = done;
        send({64'hf5, 64'hf4, 64'hf3, 64'hf2, 64'hf1}, 4, 0);
        send({64'hf15, 64'hf14, 64'hf13, 64'hf12, 64'hf11}, 4, 0);
        send({64'hf25, 64'hf24, 64'hf23, 64'hf22, 64'hf21}, 4, 0);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        wait_done(d0 + 3);
        chk("b2b_job_count", bus.job_count, 4);
        chk("b2b_packets", first_wr_q.size() - n, 3);
        for (int k = 0; k < 2 && n + k + 1 < first_wr_q.size() && ob + k < last_beat_q.size(); k++)
            chk("b2b_accept_after_tlast", first_wr_q[n + k + 1], last_beat_q[ob + k] + 1);
        chk("b2b_max_outstanding", max_out <= 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
